// File: rtl/boolean_exp_solver.sv
// rtl/boolean_exp_solver.sv - inverse search over the 4-input team function.
// Optional macro BOOLEAN_EXP_SOLVER_EARLY_EXIT_EN ends the sweep at the first hit.
module boolean_exp_solver (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] target,
  input  logic [4:0] mask,
  output logic       busy,
  output logic       match_valid,
  output logic [3:0] match_abcd,
  output logic [4:0] match_count,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [4:0] target_q, target_d;
  logic [4:0] mask_q, mask_d;
  logic       valid_q, valid_d;
  logic [3:0] abcd_q, abcd_d;
  logic [4:0] count_q, count_d;
  logic       done_q, done_d;

  logic       a, b, c, d;
  logic [4:0] y;
  logic       hit;
  logic       last;

  assign {a, b, c, d} = idx_q;

  // y = {Y5,Y4,Y3,Y2,Y1} for the candidate currently indexed by idx_q
  always_comb begin
    y    = 5'd0;
    y[0] = (a ^ b) & (c | ~d);
    y[1] = ~((a & b) | (c & ~d));
    y[2] = (a & b) | (b & c) | (a & c);
    y[3] = (a & (~b | c)) ^ (d & (b | ~c));
    y[4] = ~((a | b) ^ (c & ~d));
  end

  assign hit = (((y ^ target_q) & mask_q) == 5'd0);

`ifdef BOOLEAN_EXP_SOLVER_EARLY_EXIT_EN
  assign last = (idx_q == 4'd15) || hit;
`else
  assign last = (idx_q == 4'd15);
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    target_d = target_q;
    mask_d   = mask_q;
    valid_d  = 1'b0;
    abcd_d   = abcd_q;
    count_d  = count_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SCAN;
          idx_d    = 4'd0;
          target_d = target;
          mask_d   = mask;
          count_d  = 5'd0;
        end
      end
      SCAN: begin
        valid_d = hit;
        if (hit) begin
          abcd_d = idx_q;
        end
        count_d = count_q + {4'd0, hit};
        idx_d   = idx_q + 4'd1;
        if (last) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= 4'd0;
      target_q <= 5'd0;
      mask_q   <= 5'd0;
      valid_q  <= 1'b0;
      abcd_q   <= 4'd0;
      count_q  <= 5'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      target_q <= target_d;
      mask_q   <= mask_d;
      valid_q  <= valid_d;
      abcd_q   <= abcd_d;
      count_q  <= count_d;
      done_q   <= done_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign match_valid = valid_q;
  assign match_abcd  = abcd_q;
  assign match_count = count_q;
  assign done        = done_q;

endmodule

// File: doc/boolean_exp_solver.md
BOOLEAN_EXP_SOLVER -- requirements
Module: boolean_exp_solver

Interface
REQ-001 Parameter: none; all widths are fixed.
REQ-002 clk  input  1  Single clock; all state updates on the rising edge.
REQ-003 rst  input  1  Reset, synchronous, active-high.
REQ-004 start  input  1  Request a new scan; sampled only in IDLE.
REQ-005 target  input  5  Required output pattern {Y5,Y4,Y3,Y2,Y1}.
REQ-006 mask  input  5  Compare enable per bit; a 0 bit is "don't care".
REQ-007 busy  output  1  High while a scan is in progress (SCAN or DONE).
REQ-008 match_valid  output  1  One-cycle pulse: match_abcd holds a matching input.
REQ-009 match_abcd  output  4  Matching input vector {A,B,C,D}, where A = bit 3.
REQ-010 match_count  output  5  Number of matches in the current or last scan (0..16).
REQ-011 done  output  1  One-cycle pulse marking the end of a scan.

Function
REQ-012 The block SHALL be the inverse of the team's 4-input function: it sweeps every input {A,B,C,D} and reports each input whose outputs equal target on the masked bits.
REQ-013 Evaluated function: Y1=(A^B)&(C|~D); Y2=~((A&B)|(C&~D)); Y3=AB|BC|AC; Y4=(A&(~B|C))^(D&(B|~C)); Y5=~((A|B)^(C&~D)).
REQ-014 The block SHALL have three states: IDLE, SCAN, DONE.
REQ-015 IDLE to SCAN: start=1 at an edge latches target and mask, sets idx=0, clears match_count and sets busy=1.
REQ-016 In SCAN with idx=i, the hit condition is ((Y^target_q)&mask_q)==0.
REQ-017 At each SCAN edge: match_valid<=hit, match_abcd<=i (updated only on a hit), match_count<=match_count+hit, idx<=i+1.
REQ-018 idx=0..15 SHALL be evaluated in ascending order, one per cycle, with no gaps.
REQ-019 At the edge that evaluates idx=15, the state SHALL go to DONE and done<=1.
  - done therefore coincides with the last match_valid.
REQ-020 DONE lasts exactly one cycle; the next edge goes to IDLE with done=0 and busy=0.
REQ-021 Latency: start edge E0; idx i is reported in the cycle after edge E(1+i); busy is high for 17 cycles.
REQ-022 start is ignored in SCAN and DONE; start in the DONE cycle does not start a new scan.
REQ-023 target and mask changes after E0 SHALL NOT affect the scan in progress.
REQ-024 mask=0 means every idx hits: match_count=16 and there are 16 match_valid pulses.
REQ-025 match_count and match_abcd SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, idx=0, busy=0, match_valid=0, match_abcd=0, match_count=0 and done=0; this overrides start.
REQ-027 Reset mid-scan SHALL abort the scan with no done pulse.
  - start on the first cycle after reset is accepted normally.

Configuration
REQ-028 Macro BOOLEAN_EXP_SOLVER_EARLY_EXIT_EN.
  - Defined: the first hit SHALL move the state to DONE at the same edge, so match_valid and done pulse together and match_count<=1.
  - Defined, no hit: the scan runs the full sweep per REQ-019.
  - Undefined: the full 16-input sweep always runs.

Verification
REQ-029 Y3-only search: mask=5'b00100, target=5'b00100, start.
  - 8 match_valid pulses, at idx 6, 7, 10, 11, 12, 13, 14, 15.
  - match_count=8; done comes 17 cycles after start.
REQ-030 Full-pattern search: mask=5'b11111, target=5'b10010.
  - Matches at idx 0 and 3 only; match_count=2.
REQ-031 Don't-care search: mask=5'b00000.
  - 16 consecutive match_valid pulses, match_abcd going 0..15, match_count=16.
REQ-032 Start while busy: pulse start again 5 cycles into the REQ-029 scan with different target and mask.
  - The scan result is unchanged; done fires once.
REQ-033 Mid-scan reset: rst for 1 cycle at idx=8 of the REQ-031 scan.
  - All outputs 0 and no done pulse.
  - start in the next cycle yields a full, correct scan.
REQ-034 With BOOLEAN_EXP_SOLVER_EARLY_EXIT_EN defined, repeat REQ-029.
  - A single match_valid with match_abcd=6, done in the same cycle, match_count=1, busy low the following cycle.
